// File: rtl/seq_pkg.sv
// Shared definitions for the op_sequencer command path: core opcodes,
// sequencer states and the opcode legality rule.
package seq_pkg;

   typedef enum logic [3:0] {
      OP_LOAD     = 4'd0,
      OP_SHIFT_R  = 4'd1,
      OP_SHIFT_L  = 4'd2,
      OP_SHIFT_U  = 4'd3,
      OP_SHIFT_D  = 4'd4,
      OP_REDUCE   = 4'd5,
      OP_INCREASE = 4'd6,
      OP_DISPLAY  = 4'd7,
      OP_CONV     = 4'd8,
      OP_MEDIAN   = 4'd9,
      OP_SGNMS    = 4'd10
   } op_t;

   localparam logic [3:0] OP_LAST = 4'd10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READY,
      S_ISSUE,
      S_LOAD,
      S_WAIT
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_LAST;
   endfunction

endpackage

// File: rtl/op_sequencer_if.sv
// Host, load-source and core handshake bundle of the op_sequencer.
// The sequencer sits on the slave modport; host/core side uses master.
interface op_sequencer_if;
   logic        i_cmd_valid;
   logic [3:0]  i_cmd_op;
   logic        o_cmd_ready;
   logic        i_src_valid;
   logic [7:0]  i_src_data;
   logic        o_src_ready;
   logic        o_op_valid;
   logic [3:0]  o_op_mode;
   logic        i_op_ready;
   logic        o_in_valid;
   logic [7:0]  o_in_data;
   logic        i_in_ready;
   logic        i_out_valid;
   logic        o_done;
   logic [11:0] o_out_cnt;
   logic        o_err;
   logic        o_hang;

   modport slave (
      input  i_cmd_valid, i_cmd_op, i_src_valid, i_src_data,
             i_op_ready, i_in_ready, i_out_valid,
      output o_cmd_ready, o_src_ready, o_op_valid, o_op_mode,
             o_in_valid, o_in_data, o_done, o_out_cnt, o_err, o_hang
   );

   modport master (
      output i_cmd_valid, i_cmd_op, i_src_valid, i_src_data,
             i_op_ready, i_in_ready, i_out_valid,
      input  o_cmd_ready, o_src_ready, o_op_valid, o_op_mode,
             o_in_valid, o_in_data, o_done, o_out_cnt, o_err, o_hang
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; pushes when full and pops
// when empty are ignored. DEPTH must be a power of two.
module sync_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push_ok;
   logic             pop_ok;

   assign o_full  = (count == CW'(DEPTH));
   assign o_empty = (count == '0);
   assign o_count = count;
   assign o_rdata = mem[rd_ptr];
   assign push_ok = i_push && !o_full;
   assign pop_ok  = i_pop && !o_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries data only, so it is left out of reset.
   always_ff @(posedge i_clk) begin
      if (push_ok) mem[wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/op_sequencer.sv
// Command sequencer: queues host ops, issues them to the core's one-shot
// handshake, streams LOAD bytes and counts output beats per op.
module op_sequencer
   import seq_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int LOAD_BYTES = 2048,
   parameter int TIMEOUT    = 4096
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   op_sequencer_if.slave bus
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
   localparam logic [11:0]     LOAD_LAST = 12'(LOAD_BYTES - 1);

   state_t                    state;
   logic                      core_rdy;
   logic [11:0]               byte_cnt;
   logic [11:0]               beat_cnt;
   logic [WD_W-1:0]           wd_cnt;
   logic                      fifo_push;
   logic                      fifo_pop;
   logic [3:0]                fifo_head;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] unused_fifo_cnt;
   logic                      xfer;

   function automatic logic [11:0] sat_inc(input logic [11:0] v, input logic inc);
      if (inc && (v != 12'hFFF)) return v + 12'd1;
      return v;
   endfunction

   assign fifo_push = bus.i_cmd_valid && !fifo_full;
   assign fifo_pop  = (state == S_READY) && !fifo_empty;

   sync_fifo #(
      .WIDTH (4),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (fifo_push),
      .i_wdata (bus.i_cmd_op),
      .i_pop   (fifo_pop),
      .o_rdata (fifo_head),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (unused_fifo_cnt)
   );

   // Load path is a pure pass-through gated by the LOAD state.
   assign xfer            = (state == S_LOAD) && bus.i_src_valid && bus.i_in_ready;
   assign bus.o_cmd_ready = !fifo_full;
   assign bus.o_src_ready = (state == S_LOAD) && bus.i_in_ready;
   assign bus.o_in_valid  = xfer;
   assign bus.o_in_data   = (state == S_LOAD) ? bus.i_src_data : 8'd0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= S_IDLE;
         core_rdy       <= 1'b0;
         byte_cnt       <= '0;
         beat_cnt       <= '0;
         wd_cnt         <= '0;
         bus.o_op_valid <= 1'b0;
         bus.o_op_mode  <= '0;
         bus.o_done     <= 1'b0;
         bus.o_out_cnt  <= '0;
         bus.o_err      <= 1'b0;
         bus.o_hang     <= 1'b0;
      end else begin
         bus.o_op_valid <= 1'b0;
         bus.o_done     <= 1'b0;
         bus.o_err      <= 1'b0;
         // Ready pulses are remembered even while nothing is queued.
         if (bus.i_op_ready) core_rdy <= 1'b1;

         case (state)
            S_IDLE: begin
               if (core_rdy) state <= S_READY;
            end
            S_READY: begin
               if (!fifo_empty) begin
                  if (op_legal(fifo_head)) begin
                     bus.o_op_valid <= 1'b1;
                     bus.o_op_mode  <= fifo_head;
                     state          <= S_ISSUE;
                  end else begin
                     bus.o_err <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               core_rdy <= 1'b0;
               beat_cnt <= '0;
               byte_cnt <= '0;
               wd_cnt   <= '0;
               state    <= (bus.o_op_mode == OP_LOAD) ? S_LOAD : S_WAIT;
            end
            S_LOAD: begin
               if (xfer) begin
                  byte_cnt <= byte_cnt + 12'd1;
                  if (byte_cnt == LOAD_LAST) state <= S_WAIT;
               end
            end
            S_WAIT: begin
               beat_cnt <= sat_inc(beat_cnt, bus.i_out_valid);
               if (bus.i_op_ready) begin
                  bus.o_done    <= 1'b1;
                  bus.o_out_cnt <= sat_inc(beat_cnt, bus.i_out_valid);
                  state         <= S_READY;
               end else if (wd_cnt == WD_LAST) begin
                  // Abandon the stuck op; queued commands survive.
                  bus.o_hang <= 1'b1;
                  state      <= S_IDLE;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer with a queue-based reference model that is
// compared against every output on each falling clock edge.
module tb_op_sequencer;

   localparam int FIFO_DEPTH = 4;
   localparam int LOAD_BYTES = 2048;
   localparam int TIMEOUT    = 4096;

   localparam int P_WAIT_CORE = 0;
   localparam int P_POP       = 1;
   localparam int P_STROBE    = 2;
   localparam int P_STREAM    = 3;
   localparam int P_BUSY      = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   op_sequencer_if bus();

   op_sequencer #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .LOAD_BYTES (LOAD_BYTES),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   int q[$];
   bit m_rdy;
   int m_phase, m_loaded, m_beats, m_wd;
   bit e_op_valid, e_done, e_err, e_hang;
   int e_mode, e_cnt;

   task automatic model_reset();
      q.delete();
      m_rdy = 0; m_phase = P_WAIT_CORE; m_loaded = 0; m_beats = 0; m_wd = 0;
      e_op_valid = 0; e_done = 0; e_err = 0; e_hang = 0; e_mode = 0; e_cnt = 0;
   endtask

   task automatic model_step();
      int  old_phase, head;
      bit  push_ok, opr;
      old_phase = m_phase;
      push_ok   = bus.i_cmd_valid && (q.size() < FIFO_DEPTH);
      opr       = bus.i_op_ready;
      e_op_valid = 0; e_done = 0; e_err = 0;
      case (m_phase)
         P_WAIT_CORE: if (m_rdy) m_phase = P_POP;
         P_POP: if (q.size() != 0) begin
            head = q.pop_front();
            if (head > 10) e_err = 1;
            else begin e_op_valid = 1; e_mode = head; m_phase = P_STROBE; end
         end
         P_STROBE: begin
            m_loaded = 0; m_beats = 0; m_wd = 0;
            m_phase = (e_mode == 0) ? P_STREAM : P_BUSY;
         end
         P_STREAM: if (bus.i_src_valid && bus.i_in_ready) begin
            m_loaded++;
            if (m_loaded == LOAD_BYTES) m_phase = P_BUSY;
         end
         P_BUSY: begin
            if (bus.i_out_valid && m_beats < 4095) m_beats++;
            if (opr) begin
               e_done = 1; e_cnt = m_beats; m_phase = P_POP;
            end else begin
               m_wd++;
               if (m_wd == TIMEOUT) begin e_hang = 1; m_phase = P_WAIT_CORE; end
            end
         end
         default: ;
      endcase
      if (old_phase == P_STROBE) m_rdy = 0;
      else if (opr) m_rdy = 1;
      if (push_ok) q.push_back(int'(bus.i_cmd_op));
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("cmd_ready", bus.o_cmd_ready, q.size() < FIFO_DEPTH);
         chk("op_valid",  bus.o_op_valid, e_op_valid);
         chk("op_mode",   bus.o_op_mode, e_mode);
         chk("done",      bus.o_done, e_done);
         chk("out_cnt",   bus.o_out_cnt, e_cnt);
         chk("err",       bus.o_err, e_err);
         chk("hang",      bus.o_hang, e_hang);
         chk("src_ready", bus.o_src_ready, (m_phase == P_STREAM) && bus.i_in_ready);
         chk("in_valid",  bus.o_in_valid,
             (m_phase == P_STREAM) && bus.i_src_valid && bus.i_in_ready);
         chk("in_data",   bus.o_in_data, (m_phase == P_STREAM) ? bus.i_src_data : 8'd0);
      end
   end

   // ---------------- event monitor ----------------
   int mon_issued[$];
   int mon_done = 0;
   int mon_err  = 0;
   int mon_in   = 0;

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.o_op_valid) begin
               mon_issued.push_back(int'(bus.o_op_mode));
               chk("issued_mode_legal", bus.o_op_mode <= 4'd10, 1);
            end
            if (bus.o_done) mon_done++;
            if (bus.o_err)  mon_err++;
            if (bus.o_in_valid) begin
               chk("in_data_order", bus.o_in_data, mon_in % 256);
               mon_in++;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "global timeout");
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input int op);
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_op    = 4'(op);
      tick();
      bus.i_cmd_valid = 1'b0;
   endtask

   task automatic pulse_op_ready();
      bus.i_op_ready = 1'b1;
      tick();
      bus.i_op_ready = 1'b0;
   endtask

   task automatic wait_op_valid(input string name, input int exp_mode);
      bit found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (bus.o_op_valid) found = 1;
         else tick();
      end
      chk({name, "_issued"}, found, 1);
      if (found) chk({name, "_mode"}, bus.o_op_mode, exp_mode);
   endtask

   task automatic wait_done(input string name, input int exp_cnt);
      bit found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (bus.o_done) found = 1;
         else tick();
      end
      chk({name, "_done"}, found, 1);
      if (found) chk({name, "_out_cnt"}, bus.o_out_cnt, exp_cnt);
   endtask

   // ---------------- directed tests ----------------
   int ops[5] = '{1, 2, 3, 4, 6};

   initial begin
      int k, cyc, n, base, snap;
      bit x;
      bus.i_cmd_valid = 0; bus.i_cmd_op = 0; bus.i_src_valid = 0; bus.i_src_data = 0;
      bus.i_op_ready = 0; bus.i_in_ready = 0; bus.i_out_valid = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_cmd_ready", bus.o_cmd_ready, 1);
      chk("rst_op_valid",  bus.o_op_valid, 0);
      chk("rst_out_cnt",   bus.o_out_cnt, 0);
      chk("rst_hang",      bus.o_hang, 0);

      // T1: SHIFT_R issued two cycles after the push, done with zero beats
      pulse_op_ready();
      repeat (3) tick();
      push(1);
      chk("t1_lat_t1", bus.o_op_valid, 0);
      tick();
      chk("t1_lat_t2", bus.o_op_valid, 1);
      chk("t1_mode",   bus.o_op_mode, 1);
      tick();
      chk("t1_one_cycle", bus.o_op_valid, 0);
      repeat (2) tick();
      pulse_op_ready();
      wait_done("t1", 0);

      // T2: LOAD with random gaps on both sides
      tick();
      push(0);
      wait_op_valid("t2", 0);
      k = 0; cyc = 0;
      while (k < LOAD_BYTES && cyc < 20000) begin
         bus.i_src_valid = ($urandom_range(3) != 0);
         bus.i_in_ready  = ($urandom_range(3) != 0);
         bus.i_src_data  = k[7:0];
         @(negedge clk);
         x = bus.i_src_valid && bus.i_in_ready && bus.o_src_ready;
         tick();
         if (x) k++;
         cyc++;
      end
      chk("t2_bytes_sent", k, LOAD_BYTES);
      bus.i_src_valid = 1; bus.i_in_ready = 1;
      repeat (3) begin
         tick();
         chk("t2_src_ready_after", bus.o_src_ready, 0);
      end
      chk("t2_in_beats", mon_in, LOAD_BYTES);
      bus.i_src_valid = 0; bus.i_in_ready = 0;
      pulse_op_ready();
      wait_done("t2", 0);

      // T3: DISPLAY, 128 beats with the last one coincident with op_ready
      tick();
      snap = mon_done;
      push(7);
      wait_op_valid("t3", 7);
      tick();
      n = 0; cyc = 0;
      while (n < 127 && cyc < 2000) begin
         bus.i_out_valid = ($urandom_range(1) == 1);
         tick();
         if (bus.i_out_valid) n++;
         cyc++;
      end
      bus.i_out_valid = 1; bus.i_op_ready = 1;
      tick();
      bus.i_out_valid = 0; bus.i_op_ready = 0;
      wait_done("t3", 128);
      repeat (3) tick();
      chk("t3_done_pulses", mon_done - snap, 1);

      // T4: illegal opcode dropped, MEDIAN issued
      snap = mon_err;
      push(12);
      push(9);
      wait_op_valid("t4", 9);
      repeat (2) tick();
      chk("t4_err_pulses", mon_err - snap, 1);
      pulse_op_ready();
      wait_done("t4", 0);

      // T5: reset, fill FIFO without core ready, then drain in order
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      base = mon_issued.size();
      snap = mon_done;
      for (int i = 0; i < 4; i++) push(ops[i]);
      bus.i_cmd_valid = 1; bus.i_cmd_op = 4'(ops[4]);
      chk("t5_full_after_4", bus.o_cmd_ready, 0);
      repeat (3) tick();
      chk("t5_still_full", bus.o_cmd_ready, 0);
      pulse_op_ready();
      for (int i = 0; i < 20 && !bus.o_cmd_ready; i++) tick();
      chk("t5_space_freed", bus.o_cmd_ready, 1);
      tick();
      bus.i_cmd_valid = 0;
      for (int i = 0; i < 5; i++) begin
         repeat (3) tick();
         pulse_op_ready();
         wait_done("t5", 0);
      end
      repeat (3) tick();
      chk("t5_issued_count", mon_issued.size() - base, 5);
      for (int i = 0; i < 5; i++)
         chk("t5_drain_order",
             (base + i < mon_issued.size()) ? mon_issued[base + i] : -1, ops[i]);
      chk("t5_done_count", mon_done - snap, 5);

      // T6: CONV never completes -> sticky hang, queued SHIFT_D preserved
      push(8);
      push(4);
      wait_op_valid("t6", 8);
      n = 0;
      while (!bus.o_hang && n < 5000) begin
         tick();
         n++;
      end
      chk("t6_hang_latency", n, TIMEOUT + 1);
      repeat (10) tick();
      chk("t6_hang_sticky", bus.o_hang, 1);
      pulse_op_ready();
      wait_op_valid("t6_after_hang", 4);
      repeat (2) tick();
      pulse_op_ready();
      wait_done("t6", 0);
      chk("t6_hang_kept", bus.o_hang, 1);

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
